// File: rtl/aclk_key_controller.sv
//==============================================================================
// Module      : aclk_key_controller
// Description : Keypad front end of the alarm clock. Shifts entered digits
//               into an HH:MM buffer and commits it as alarm or current time.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module aclk_key_controller #(
    parameter int TIMEOUT_S = 10,
    parameter int CNT_W     = 4,
    parameter int KEY_ALARM = 10,
    parameter int KEY_TIME  = 11
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       one_second,
    input  logic       key_valid,
    input  logic [3:0] key,
    output logic [3:0] key_ms_hr,
    output logic [3:0] key_ls_hr,
    output logic [3:0] key_ms_min,
    output logic [3:0] key_ls_min,
    output logic       show_new_time,
    output logic       show_a,
    output logic       load_new_a,
    output logic       load_new_c,
    output logic       reset_count,
    output logic       entry_error
);

    localparam logic [1:0] S_SHOW_TIME  = 2'd0;
    localparam logic [1:0] S_KEY_ENTRY  = 2'd1;
    localparam logic [1:0] S_SHOW_ALARM = 2'd2;

    localparam logic [3:0]       c_key_alarm = 4'(KEY_ALARM);
    localparam logic [3:0]       c_key_time  = 4'(KEY_TIME);
    localparam logic [CNT_W-1:0] c_cnt_last  = CNT_W'(TIMEOUT_S - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_ms_hr, r_ls_hr, r_ms_min, r_ls_min;
    logic             r_show_new_time, r_show_a;
    logic             r_load_new_a, r_load_new_c, r_reset_count, r_entry_error;

    logic       w_digit, w_alarm, w_time, w_accepted, w_expired, w_in_range;
    logic [6:0] w_hours;

    assign w_digit    = key_valid && (key <= 4'd9);
    assign w_alarm    = key_valid && (key == c_key_alarm);
    assign w_time     = key_valid && (key == c_key_time);
    assign w_accepted = w_digit || w_alarm || w_time;
    assign w_expired  = one_second && (r_cnt == c_cnt_last);

    assign w_hours    = ({3'b000, r_ms_hr} * 7'd10) + {3'b000, r_ls_hr};
    assign w_in_range = (w_hours <= 7'd23) && (r_ms_min <= 4'd5) &&
                        (r_ls_hr <= 4'd9) && (r_ls_min <= 4'd9);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= S_SHOW_TIME;
            r_cnt           <= '0;
            r_ms_hr         <= 4'd0;
            r_ls_hr         <= 4'd0;
            r_ms_min        <= 4'd0;
            r_ls_min        <= 4'd0;
            r_show_new_time <= 1'b0;
            r_show_a        <= 1'b0;
            r_load_new_a    <= 1'b0;
            r_load_new_c    <= 1'b0;
            r_reset_count   <= 1'b0;
            r_entry_error   <= 1'b0;
        end else begin
            r_load_new_a  <= 1'b0;
            r_load_new_c  <= 1'b0;
            r_reset_count <= 1'b0;
            r_entry_error <= 1'b0;

            case (r_state)
                S_SHOW_TIME: begin
                    // Buffer is idle here; this also clears it the cycle after a commit.
                    r_cnt    <= '0;
                    r_ms_hr  <= 4'd0;
                    r_ls_hr  <= 4'd0;
                    r_ms_min <= 4'd0;
                    r_ls_min <= w_digit ? key : 4'd0;
                    if (w_digit) begin
                        r_state         <= S_KEY_ENTRY;
                        r_show_new_time <= 1'b1;
                    end else if (w_alarm) begin
                        r_state  <= S_SHOW_ALARM;
                        r_show_a <= 1'b1;
                    end
                end

                S_KEY_ENTRY: begin
                    if (w_digit) begin
                        r_cnt    <= '0;
                        r_ms_hr  <= r_ls_hr;
                        r_ls_hr  <= r_ms_min;
                        r_ms_min <= r_ls_min;
                        r_ls_min <= key;
                    end else if (w_alarm || w_time) begin
                        r_cnt           <= '0;
                        r_state         <= S_SHOW_TIME;
                        r_show_new_time <= 1'b0;
                        if (!w_in_range) begin
                            r_entry_error <= 1'b1;
                        end else if (w_alarm) begin
                            r_load_new_a <= 1'b1;
                        end else begin
                            r_load_new_c  <= 1'b1;
                            r_reset_count <= 1'b1;
                        end
                    end else if (w_expired) begin
                        r_cnt           <= '0;
                        r_state         <= S_SHOW_TIME;
                        r_show_new_time <= 1'b0;
                        r_ms_hr         <= 4'd0;
                        r_ls_hr         <= 4'd0;
                        r_ms_min        <= 4'd0;
                        r_ls_min        <= 4'd0;
                    end else if (one_second) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_SHOW_ALARM: begin
                    // Ignored digit/TIME presses still count as activity.
                    if (w_alarm || w_expired) begin
                        r_cnt    <= '0;
                        r_state  <= S_SHOW_TIME;
                        r_show_a <= 1'b0;
                    end else if (w_accepted) begin
                        r_cnt <= '0;
                    end else if (one_second) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state         <= S_SHOW_TIME;
                    r_cnt           <= '0;
                    r_show_new_time <= 1'b0;
                    r_show_a        <= 1'b0;
                end
            endcase
        end
    end

    assign key_ms_hr     = r_ms_hr;
    assign key_ls_hr     = r_ls_hr;
    assign key_ms_min    = r_ms_min;
    assign key_ls_min    = r_ls_min;
    assign show_new_time = r_show_new_time;
    assign show_a        = r_show_a;
    assign load_new_a    = r_load_new_a;
    assign load_new_c    = r_load_new_c;
    assign reset_count   = r_reset_count;
    assign entry_error   = r_entry_error;

endmodule

`default_nettype wire

// File: tb/tb_aclk_key_controller.sv
//==============================================================================
// Module      : tb_aclk_key_controller
// Description : Directed vector bench for the alarm-clock keypad controller.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_aclk_key_controller;

    localparam int TIMEOUT_S = 10;
    localparam logic [3:0] c_ka = 4'd10;
    localparam logic [3:0] c_kt = 4'd11;

    logic       clock = 1'b0;
    logic       reset;
    logic       one_second;
    logic       key_valid;
    logic [3:0] key;
    logic [3:0] key_ms_hr, key_ls_hr, key_ms_min, key_ls_min;
    logic       show_new_time, show_a, load_new_a, load_new_c, reset_count, entry_error;

    int checks = 0;
    int errors = 0;

    // flags = {show_new_time, show_a, load_new_a, load_new_c, reset_count, entry_error}
    typedef struct {
        logic        kv;
        logic [3:0]  k;
        logic        os;
        logic [15:0] digits;
        logic [5:0]  flags;
    } vec_t;

    vec_t vecs[$];

    aclk_key_controller #(
        .TIMEOUT_S (TIMEOUT_S),
        .CNT_W     (4),
        .KEY_ALARM (10),
        .KEY_TIME  (11)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .one_second    (one_second),
        .key_valid     (key_valid),
        .key           (key),
        .key_ms_hr     (key_ms_hr),
        .key_ls_hr     (key_ls_hr),
        .key_ms_min    (key_ms_min),
        .key_ls_min    (key_ls_min),
        .show_new_time (show_new_time),
        .show_a        (show_a),
        .load_new_a    (load_new_a),
        .load_new_c    (load_new_c),
        .reset_count   (reset_count),
        .entry_error   (entry_error)
    );

    always #5 clock = ~clock;

    task automatic add(input logic kv, input logic [3:0] k, input logic os,
                       input logic [15:0] d, input logic [5:0] f);
        vec_t v;
        v.kv = kv; v.k = k; v.os = os; v.digits = d; v.flags = f;
        vecs.push_back(v);
    endtask

    // Called at a negedge: drive inputs, let one rising edge pass, return at next negedge.
    task automatic step(input logic kv, input logic [3:0] k, input logic os);
        key_valid  = kv;
        key        = k;
        one_second = os;
        @(posedge clock);
        @(negedge clock);
        key_valid  = 1'b0;
        key        = 4'd0;
        one_second = 1'b0;
    endtask

    task automatic check(input string name, input logic [15:0] d, input logic [5:0] f);
        logic [15:0] ad;
        logic [5:0]  af;
        ad = {key_ms_hr, key_ls_hr, key_ms_min, key_ls_min};
        af = {show_new_time, show_a, load_new_a, load_new_c, reset_count, entry_error};
        checks++;
        if (ad !== d || af !== f) begin
            errors++;
            $display("FAIL %s: got digits=%h flags=%b, expected digits=%h flags=%b",
                     name, ad, af, d, f);
        end
    endtask

    initial begin
        reset      = 1'b1;
        one_second = 1'b0;
        key_valid  = 1'b0;
        key        = 4'd0;

        // 1: valid alarm 12:30
        add(1, 4'd1, 0, 16'h0001, 6'b100000);
        add(1, 4'd2, 0, 16'h0012, 6'b100000);
        add(1, 4'd3, 0, 16'h0123, 6'b100000);
        add(1, 4'd0, 0, 16'h1230, 6'b100000);
        add(1, c_ka, 0, 16'h1230, 6'b001000);
        add(0, 4'd0, 0, 16'h0000, 6'b000000);
        // 2: valid time 09:45
        add(1, 4'd0, 0, 16'h0000, 6'b100000);
        add(1, 4'd9, 0, 16'h0009, 6'b100000);
        add(1, 4'd4, 0, 16'h0094, 6'b100000);
        add(1, 4'd5, 0, 16'h0945, 6'b100000);
        add(1, c_kt, 0, 16'h0945, 6'b000110);
        add(0, 4'd0, 0, 16'h0000, 6'b000000);
        // boundary: 23:59 accepted
        add(1, 4'd2, 0, 16'h0002, 6'b100000);
        add(1, 4'd3, 0, 16'h0023, 6'b100000);
        add(1, 4'd5, 0, 16'h0235, 6'b100000);
        add(1, 4'd9, 0, 16'h2359, 6'b100000);
        add(1, c_kt, 0, 16'h2359, 6'b000110);
        add(0, 4'd0, 0, 16'h0000, 6'b000000);
        // 3: hour 25 rejected, minutes 60 rejected
        add(1, 4'd2, 0, 16'h0002, 6'b100000);
        add(1, 4'd5, 0, 16'h0025, 6'b100000);
        add(1, 4'd0, 0, 16'h0250, 6'b100000);
        add(1, 4'd0, 0, 16'h2500, 6'b100000);
        add(1, c_ka, 0, 16'h2500, 6'b000001);
        add(0, 4'd0, 0, 16'h0000, 6'b000000);
        add(1, 4'd1, 0, 16'h0001, 6'b100000);
        add(1, 4'd2, 0, 16'h0012, 6'b100000);
        add(1, 4'd6, 0, 16'h0126, 6'b100000);
        add(1, 4'd0, 0, 16'h1260, 6'b100000);
        add(1, c_kt, 0, 16'h1260, 6'b000001);
        add(0, 4'd0, 0, 16'h0000, 6'b000000);
        // 5: alarm view; digit ignored; TIME ignored in SHOW_TIME; code 15 ignored
        add(1, c_kt, 0, 16'h0000, 6'b000000);
        add(1, 4'd15, 0, 16'h0000, 6'b000000);
        add(1, c_ka, 0, 16'h0000, 6'b010000);
        add(1, 4'd7, 0, 16'h0000, 6'b010000);
        add(1, c_kt, 0, 16'h0000, 6'b010000);
        add(1, c_ka, 0, 16'h0000, 6'b000000);
        add(1, 4'd3, 1, 16'h0003, 6'b100000);
        add(1, c_ka, 0, 16'h0003, 6'b001000);
        add(0, 4'd0, 0, 16'h0000, 6'b000000);

        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_state", 16'h0000, 6'b000000);
        reset = 1'b0;
        step(0, 4'd0, 0);
        check("idle_after_reset", 16'h0000, 6'b000000);

        foreach (vecs[i]) begin
            step(vecs[i].kv, vecs[i].k, vecs[i].os);
            check($sformatf("vec%0d", i), vecs[i].digits, vecs[i].flags);
        end

        // 4: five digits keep the newest four, then timeout after TIMEOUT_S seconds
        for (int d = 1; d <= 5; d++) step(1, 4'(d), 0);
        check("five_digits", 16'h2345, 6'b100000);
        for (int s = 0; s < TIMEOUT_S - 1; s++) step(0, 4'd0, 1);
        check("entry_before_timeout", 16'h2345, 6'b100000);
        step(0, 4'd0, 1);
        check("entry_timeout", 16'h0000, 6'b000000);

        // key coinciding with the expiring second wins; ignored code does not
        step(1, 4'd1, 0);
        for (int s = 0; s < TIMEOUT_S - 1; s++) step(0, 4'd0, 1);
        step(1, 4'd2, 1);
        check("key_beats_timeout", 16'h0012, 6'b100000);
        for (int s = 0; s < TIMEOUT_S - 1; s++) step(0, 4'd0, 1);
        check("count_restarted", 16'h0012, 6'b100000);
        step(1, 4'd13, 1);
        check("ignored_code_timeout", 16'h0000, 6'b000000);

        // alarm view times out
        step(1, c_ka, 0);
        for (int s = 0; s < TIMEOUT_S - 1; s++) step(0, 4'd0, 1);
        check("alarm_before_timeout", 16'h0000, 6'b010000);
        step(0, 4'd0, 1);
        check("alarm_timeout", 16'h0000, 6'b000000);

        // 6: reset mid-entry beats a concurrent key
        step(1, 4'd1, 0);
        step(1, 4'd2, 0);
        check("pre_reset_entry", 16'h0012, 6'b100000);
        reset = 1'b1;
        step(1, 4'd3, 1);
        check("reset_mid_entry", 16'h0000, 6'b000000);
        reset = 1'b0;
        step(1, 4'd4, 0);
        check("after_reset_entry", 16'h0004, 6'b100000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
